hub75_line_fetch: RTL and testbench



---
 rtl/hub75_line_fetch_pkg.sv | 33 +++
 rtl/hub75_line_fetch_if.sv | 29 ++
 rtl/hub75_line_fetch.sv | 143 ++++++++++++++
 tb/tb_hub75_line_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_line_fetch_pkg.sv
// Shared definitions for the HUB75 line fetch stage: FSM encoding, default
// geometry, pixel word field offsets and the plane bit extractor.
package hub75_pkg;

   localparam int unsigned DEFAULT_COLS       = 64;
   localparam int unsigned DEFAULT_ROWS_HALF  = 32;
   localparam int unsigned DEFAULT_COLOR_BITS = 4;

   localparam int unsigned PIX_W = 3 * DEFAULT_COLOR_BITS;

   // Field offsets inside a pixel word: R lowest, then G, then B.
   localparam int unsigned R_OFS = 0;
   localparam int unsigned G_OFS = DEFAULT_COLOR_BITS;
   localparam int unsigned B_OFS = 2 * DEFAULT_COLOR_BITS;

   typedef enum logic [2:0] {
      StIdle,
      StRdUp,
      StRdLo,
      StCapLo,
      StPush,
      StDone
   } state_t;

   // Returns {B,G,R} plane bits of one pixel word.
   function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] word,
                                             input logic [1:0]       plane);
      logic [PIX_W-1:0] shifted;
      shifted = word >> plane;
      return {shifted[B_OFS], shifted[G_OFS], shifted[R_OFS]};
   endfunction

endpackage

// File: rtl/hub75_line_fetch_if.sv
// Framebuffer read port and colour-pair stream between the line fetch stage
// (master) and its neighbours (slave: framebuffer + row driver).
interface hub75_line_fetch_if
   import hub75_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned COLOR_BITS = DEFAULT_COLOR_BITS
);

   logic                    mem_rd_en;
   logic [ADDR_W-1:0]       mem_addr;
   logic [3*COLOR_BITS-1:0] mem_rdata;
   logic                    out_valid;
   logic                    out_ready;
   logic [2:0]              color0;
   logic [2:0]              color1;
   logic [6:0]              out_col;

   modport master (
      output mem_rd_en, mem_addr, out_valid, color0, color1, out_col,
      input  mem_rdata, out_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr, out_valid, color0, color1, out_col,
      output mem_rdata, out_ready
   );

endinterface

// File: rtl/hub75_line_fetch.sv
// HUB75 line fetch: for a (row, plane) request, reads the upper and lower pixel
// of every column, extracts the plane bits and streams {color0, color1} pairs.
// Optional build macro HUB75_TEST_PATTERN_EN: test_mode=1 at start replaces
// memory reads with a column-derived pattern, same timing.
module hub75_line_fetch
   import hub75_pkg::*;
#(
   parameter int unsigned COLS       = DEFAULT_COLS,
   parameter int unsigned ROWS_HALF  = DEFAULT_ROWS_HALF,
   parameter int unsigned COLOR_BITS = DEFAULT_COLOR_BITS,
   parameter int unsigned ADDR_W     = 12
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [4:0]         row,
   input  logic [1:0]         plane,
   input  logic               test_mode,
   hub75_line_fetch_if.master bus,
   output logic               busy,
   output logic               done
);

   state_t            state_q, state_d;
   logic [6:0]        col_q, col_d;
   logic [4:0]        row_q, row_d;
   logic [1:0]        plane_q, plane_d;
   logic [2:0]        color0_q, color0_d;
   logic [2:0]        color1_q, color1_d;
   logic              rd_state;
   logic [ADDR_W-1:0] pix_row;
   logic [ADDR_W-1:0] rd_addr;
   logic [3*COLOR_BITS-1:0] pix;
   logic              pat_q;

   assign pix = bus.mem_rdata;

`ifdef HUB75_TEST_PATTERN_EN
   logic pat_d;

   // Pattern mode is chosen once per row, when the request is taken.
   always_comb begin
      pat_d = pat_q;
      if (state_q == StIdle && start) pat_d = test_mode;
   end

   // Pattern mode register.
   always_ff @(posedge clk) begin
      if (!resetn) pat_q <= 1'b0;
      else         pat_q <= pat_d;
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign pat_q            = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StIdle;
         col_q    <= '0;
         row_q    <= '0;
         plane_q  <= '0;
         color0_q <= '0;
         color1_q <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         plane_q  <= plane_d;
         color0_q <= color0_d;
         color1_q <= color1_d;
      end
   end

   // Next-state logic and per-state outputs.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      plane_d   = plane_q;
      color0_d  = color0_q;
      color1_d  = color1_q;
      rd_state  = 1'b0;
      bus.out_valid = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               row_d   = row;
               plane_d = plane;
               col_d   = '0;
               state_d = StRdUp;
            end
         end
         StRdUp: begin
            rd_state = 1'b1;
            state_d  = StRdLo;
         end
         StRdLo: begin
            // Read data for the upper pixel arrives while the lower one is requested.
            rd_state = 1'b1;
            color0_d = pat_q ? col_q[2:0] : plane_bits(pix, plane_q);
            state_d  = StCapLo;
         end
         StCapLo: begin
            color1_d = pat_q ? ~col_q[2:0] : plane_bits(pix, plane_q);
            state_d  = StPush;
         end
         StPush: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               if (col_q == 7'(COLS - 1)) begin
                  state_d = StDone;
               end else begin
                  col_d   = col_q + 7'd1;
                  state_d = StRdUp;
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Framebuffer address: upper pixel in RD_UP, lower pixel in RD_LO.
   always_comb begin
      pix_row = ADDR_W'(row_q) + ((state_q == StRdLo) ? ADDR_W'(ROWS_HALF) : '0);
      rd_addr = pix_row * ADDR_W'(COLS) + ADDR_W'(col_q);
   end

   assign bus.mem_rd_en = rd_state & ~pat_q;
   assign bus.mem_addr  = bus.mem_rd_en ? rd_addr : '0;
   assign bus.color0    = color0_q;
   assign bus.color1    = color1_q;
   assign bus.out_col   = col_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_hub75_line_fetch.sv
// Self-checking bench for hub75_line_fetch: a transaction-level timing model
// checked every cycle, plus directed literal checks from hand calculation.
module tb_hub75_line_fetch;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [4:0] row = '0;
   logic [1:0] plane = '0;
   logic       test_mode = 1'b0;
   logic       busy;
   logic       done;

   hub75_line_fetch_if #(.ADDR_W(12), .COLOR_BITS(4)) bus ();

   hub75_line_fetch dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .row       (row),
      .plane     (plane),
      .test_mode (test_mode),
      .bus       (bus),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int errors = 0;
   int key = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int memw(input int a);
      return (a ^ key) & 12'hFFF;
   endfunction

   function automatic int bits_of(input int word, input int pl);
      int r, g, b;
      r = (word >> pl) & 1;
      g = (word >> (4 + pl)) & 1;
      b = (word >> (8 + pl)) & 1;
      return b * 4 + g * 2 + r;
   endfunction

   // Framebuffer: synchronous read, one cycle latency.
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= 12'(memw(int'(bus.mem_addr)));
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state: a row in flight expects a pair at m_due, reads at m_due-3/-2.
   bit known = 0, m_active = 0, m_pat = 0, post_rst = 0;
   int m_row = 0, m_plane = 0, m_col = 0, m_due = 0, m_done_due = -1;
   int acc_cyc = 0, first_valid_cyc = -1, done_cyc = -1, hs7 = 0, rd_seen = 0;
   int rd_hist0 = 0, rd_hist1 = 0;

   always @(negedge clk) begin
      int up, lo, e_c0, e_c1;
      bit e_rd, e_valid;
      if (known) begin
         up      = m_row * 64 + m_col;
         lo      = (m_row + 32) * 64 + m_col;
         e_rd    = m_active && !m_pat && (cyc == m_due - 3 || cyc == m_due - 2);
         e_valid = m_active && cyc >= m_due;
         chk("busy", int'(busy), int'(m_active || cyc == m_done_due));
         chk("done", int'(done), int'(cyc == m_done_due));
         chk("mem_rd_en", int'(bus.mem_rd_en), int'(e_rd));
         chk("out_valid", int'(bus.out_valid), int'(e_valid));
         if (e_rd) chk("mem_addr", int'(bus.mem_addr), (cyc == m_due - 3) ? up : lo);
         if (e_valid) begin
            e_c0 = m_pat ? (m_col & 7) : bits_of(memw(up), m_plane);
            e_c1 = m_pat ? (~m_col & 7) : bits_of(memw(lo), m_plane);
            chk("out_col", int'(bus.out_col), m_col);
            chk("color0", int'(bus.color0), e_c0);
            chk("color1", int'(bus.color1), e_c1);
         end
         if (post_rst) begin
            chk("rst_addr", int'(bus.mem_addr), 0);
            chk("rst_color0", int'(bus.color0), 0);
            chk("rst_color1", int'(bus.color1), 0);
            chk("rst_out_col", int'(bus.out_col), 0);
            post_rst = 0;
         end
         if (bus.mem_rd_en === 1'b1) begin
            rd_hist1 = rd_hist0;
            rd_hist0 = int'(bus.mem_addr);
            rd_seen++;
         end
         if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done === 1'b1) done_cyc = cyc;
      end
      if (!resetn) begin
         known      = 1;
         m_active   = 0;
         m_done_due = -1;
         post_rst   = 1;
      end else if (known) begin
         if (m_active && cyc >= m_due && bus.out_ready) begin
            if (m_col == 7) hs7++;
            if (m_col == 63) begin
               m_active   = 0;
               m_done_due = cyc + 1;
            end else begin
               m_col++;
               m_due = cyc + 4;
            end
         end else if (!m_active && cyc != m_done_due && start) begin
            m_active        = 1;
            m_row           = int'(row);
            m_plane         = int'(plane);
`ifdef HUB75_TEST_PATTERN_EN
            m_pat           = test_mode;
`else
            m_pat           = 0;
`endif
            m_col           = 0;
            m_due           = cyc + 4;
            acc_cyc         = cyc;
            first_valid_cyc = -1;
            rd_seen         = 0;
            hs7             = 0;
         end
      end
   end

   task automatic start_row(input int r, input int p, input bit tm);
      row = 5'(r); plane = 2'(p); test_mode = tm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_valid_col(input int col, input int lim);
      for (int i = 0; i < lim; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1 && int'(bus.out_col) == col) return;
      end
      chk("timeout_valid_col", -1, col);
   endtask

   // Returns in the IDLE cycle following done.
   task automatic wait_done(input int lim);
      for (int i = 0; i < lim; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            @(posedge clk); #1;
            return;
         end
      end
      chk("timeout_done", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_valid", int'(bus.out_valid), 0);
      chk("reset_rd_en", int'(bus.mem_rd_en), 0);

      // T1: mem[a]=a, row 1, plane 0; column 5 reads 69 then 2117.
      key = 0;
      start_row(1, 0, 1'b0);
      wait_valid_col(5, 40);
      chk("t1_addr_up", rd_hist1, 69);
      chk("t1_addr_lo", rd_hist0, 2117);
      chk("t1_color0", int'(bus.color0), 3'b001);
      chk("t1_color1", int'(bus.color1), 3'b001);
      chk("t1_out_col", int'(bus.out_col), 5);
      wait_done(400);

      // T2: row 0, plane 3; lower word 0x800 gives B only.
      start_row(0, 3, 1'b0);
      wait_valid_col(0, 10);
      chk("t2_color0", int'(bus.color0), 3'b000);
      chk("t2_color1", int'(bus.color1), 3'b100);
      wait_done(400);
      chk("t2_first_valid_lat", first_valid_cyc - acc_cyc, 4);
      chk("t2_done_lat", done_cyc - acc_cyc, 257);

      // T3: back-pressure for 10 cycles at column 7.
      key = 12'h3C7;
      start_row(10, 1, 1'b0);
      wait_valid_col(7, 60);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("t3_hold_valid", int'(bus.out_valid), 1);
         chk("t3_hold_col", int'(bus.out_col), 7);
         chk("t3_hold_c0", int'(bus.color0), bits_of(memw(10 * 64 + 7), 1));
         chk("t3_hold_c1", int'(bus.color1), bits_of(memw(42 * 64 + 7), 1));
         chk("t3_hold_rd", int'(bus.mem_rd_en), 0);
         if (i < 9) begin
            @(posedge clk); #1;
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t3_released", int'(bus.out_valid), 0);
      wait_valid_col(8, 10);
      chk("t3_col7_once", hs7, 1);
      wait_done(400);

      // T4: starts mid-row and in the done cycle are dropped.
      key = 12'h9A1;
      start_row(3, 1, 1'b0);
      repeat (20) @(posedge clk);
      #1 start_row(9, 2, 1'b0);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) break;
      end
      chk("t4_done_seen", int'(done), 1);
      row = 5'd9; plane = 2'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("t4_idle_after_done", int'(busy), 0);
      start_row(9, 2, 1'b0);
      chk("t4_restart_busy", int'(busy), 1);
      wait_done(400);

      // T5: reset mid-row at column 30.
      start_row(2, 2, 1'b0);
      wait_valid_col(30, 200);
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      chk("t5_busy", int'(busy), 0);
      chk("t5_valid", int'(bus.out_valid), 0);
      chk("t5_out_col", int'(bus.out_col), 0);
      chk("t5_color0", int'(bus.color0), 0);
      repeat (20) @(posedge clk);
      #1 chk("t5_still_idle", int'(busy), 0);
      key = 12'h5A3;
      start_row(4, 0, 1'b0);
      wait_valid_col(0, 10);
      chk("t5_restart_c1", int'(bus.color1), bits_of(memw(36 * 64), 0));
      wait_done(400);

`ifdef HUB75_TEST_PATTERN_EN
      // T6: pattern mode, no memory traffic.
      start_row(1, 0, 1'b1);
      wait_valid_col(6, 40);
      chk("t6_color0", int'(bus.color0), 3'b110);
      chk("t6_color1", int'(bus.color1), 3'b001);
      wait_done(400);
      chk("t6_no_reads", rd_seen, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
